div32u_seq: RTL and testbench

//  Sequential unsigned divider, the inverse of the team's shift-add Mul32U.

---
 rtl/div32u_seq_pkg.sv | 14 +
 rtl/div32u_seq_if.sv | 26 ++
 rtl/div32u_seq_sub_cmp.sv | 14 +
 rtl/div32u_seq.sv | 116 +++++++++++
 tb/tb_div32u_seq.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/div32u_seq_pkg.sv
// Shared types and constants for the sequential unsigned divider.
// Holds FSM encodings and divide-by-zero result conventions.
package div32u_seq_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // x/0 yields an all-ones quotient and returns the dividend as remainder
  localparam logic DZ_QUO_FILL = 1'b1;

endpackage

// File: rtl/div32u_seq_if.sv
// Request/result bundle between the M-extension ALU path and the divider.
// The master issues operands; the slave reports status and results.
interface div32u_seq_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  modport master (
    output start, op1, op2,
    input  busy, done, dz, quo, rem
  );

  modport slave (
    input  start, op1, op2,
    output busy, done, dz, quo, rem
  );

endinterface

// File: rtl/div32u_seq_sub_cmp.sv
// Trial subtractor for one restoring-division step.
// Returns the difference and the borrow out of the top bit.
module sub_cmp #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div32u_seq.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// Results hold until the next accepted start.
module div32u_seq
  import div32u_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  div32u_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e state_q, state_d;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0] t_rem;
  logic [WIDTH:0] diff;
  logic           borrow;
  logic           take;

  // shifted-in bit keeps the carry out of r's MSB in the compare
  assign t_rem = {r_q, q_q[WIDTH-1]};

  sub_cmp #(
    .W (WIDTH + 1)
  ) u_sub_cmp (
    .a      (t_rem),
    .b      ({1'b0, d_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  assign take = ~borrow & ~diff[WIDTH];

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    unique case (state_q)
      DIV_IDLE, DIV_DONE: begin
        state_d = DIV_IDLE;
        if (bus.start) begin
          if (bus.op2 == '0) begin
            quo_d   = {WIDTH{DZ_QUO_FILL}};
            rem_d   = bus.op1;
            dz_d    = 1'b1;
            state_d = DIV_DONE;
          end else begin
            q_d     = bus.op1;
            r_d     = '0;
            d_d     = bus.op2;
            cnt_d   = '0;
            dz_d    = 1'b0;
            state_d = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        q_d   = {q_q[WIDTH-2:0], take};
        r_d   = take ? diff[WIDTH-1:0]
                     : t_rem[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          quo_d   = q_d;
          rem_d   = r_d;
          state_d = DIV_DONE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy = (state_q == DIV_RUN);
  assign bus.done = (state_q == DIV_DONE);
  assign bus.dz   = dz_q;
  assign bus.quo  = quo_q;
  assign bus.rem  = rem_q;

endmodule

// File: tb/tb_div32u_seq.sv
// Scoreboard bench for div32u_seq: directed vectors plus a short
// pseudo-random run; a monitor checks every done pulse in order.
module tb_div32u_seq;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_bad;

  typedef struct {
    logic [31:0] quo;
    logic [31:0] rem;
    logic        dz;
    int          due;
    string       tag;
  } exp_t;

  exp_t sb[$];

  div32u_seq_if #(.WIDTH(32)) bus ();

  div32u_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst && bus.done) begin
      n_vec = n_vec + 1;
      if (sb.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL unexpected_done cyc=%0d quo=%h rem=%h",
                 cyc, bus.quo, bus.rem);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.quo !== e.quo || bus.rem !== e.rem ||
            bus.dz !== e.dz || cyc != e.due || bus.busy !== 1'b0) begin
          n_bad = n_bad + 1;
          $display("FAIL %s got quo=%h rem=%h dz=%b busy=%b cyc=%0d want quo=%h rem=%h dz=%b busy=0 cyc=%0d",
                   e.tag, bus.quo, bus.rem, bus.dz, bus.busy, cyc,
                   e.quo, e.rem, e.dz, e.due);
        end
      end
    end
  end

  // called at a negedge just before the accepting posedge
  function automatic void push_exp(input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic [31:0] eq,
                                   input logic [31:0] er,
                                   input string tag);
    exp_t e;
    e.quo = eq;
    e.rem = er;
    e.dz  = (b == 32'd0);
    e.due = cyc + 1 + ((b == 32'd0) ? 0 : 32);
    e.tag = tag;
    sb.push_back(e);
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er,
                       input string tag);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op1   = a;
    bus.op2   = b;
    push_exp(a, b, eq, er, tag);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    if (sb.size() != 0) begin
      n_vec = n_vec + 1;
      n_bad = n_bad + 1;
      $display("FAIL timeout pending=%0d want pending=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    n_vec = n_vec + 1;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dz !== 1'b0 ||
        bus.quo !== 32'd0 || bus.rem !== 32'd0) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got busy=%b done=%b dz=%b quo=%h rem=%h want all zero",
               tag, bus.busy, bus.done, bus.dz, bus.quo, bus.rem);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          k;
    cyc       = 0;
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.op1   = '0;
    bus.op2   = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    issue(32'd100, 32'd7, 32'd14, 32'd2, "basic_100_7");
    drain();
    issue(32'hFFFFFFFF, 32'h80000000, 32'd1, 32'h7FFFFFFF, "big_div_msb");
    drain();
    issue(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, "div_by_one");
    drain();
    issue(32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, "div_zero");
    drain();
    issue(32'd0, 32'd13, 32'd0, 32'd0, "zero_dividend");
    drain();
    issue(32'd77, 32'd77, 32'd1, 32'd0, "equal_ops");
    drain();
    issue(32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE, "a_lt_b_big");
    drain();

    // back-to-back: start held in DONE
    issue(32'd5, 32'd9, 32'd0, 32'd5, "small_5_9");
    k = 0;
    while (bus.done !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    bus.start = 1'b1;
    bus.op1   = 32'd9;
    bus.op2   = 32'd9;
    push_exp(32'd9, 32'd9, 32'd1, 32'd0, "b2b_9_9");
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // start while RUN must be ignored
    issue(32'd50, 32'd5, 32'd10, 32'd0, "busy_ignore");
    repeat (8) @(negedge clk);
    bus.start = 1'b1;
    bus.op1   = 32'd77;
    bus.op2   = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    // asynchronous abort in the middle of RUN
    issue(32'd1000, 32'd3, 32'd333, 32'd1, "aborted");
    repeat (13) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_zero("async_abort");
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    issue(32'd200, 32'd6, 32'd33, 32'd2, "after_reset");
    drain();

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (i % 6 == 0) b = 32'd0;
      if (b == 32'd0)
        issue(a, b, 32'hFFFFFFFF, a, "random_dz");
      else
        issue(a, b, a / b, a % b, "random");
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
